// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard/sequencing
//                controller and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Controller sequencing states: normal issue, or frozen on a data-memory access
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    // Architectural zero register: writes to it never create a dependency
    localparam int REG_ZERO = 0;

    // A data-memory access that has not completed this cycle
    function automatic logic mem_busy_f(input logic req, input logic ready);
        return req & ~ready;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_if
//  Description : Hazard inputs and pipeline-control outputs exchanged between
//                the datapath (master) and the pipeline controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if #(
    parameter int REG_BITS  = 5,
    parameter int CNT_WIDTH = 32
);
    // Decode / execute / memory stage status
    logic [REG_BITS-1:0]  id_rs1;
    logic [REG_BITS-1:0]  id_rs2;
    logic                 id_uses_rs1;
    logic                 id_uses_rs2;
    logic [REG_BITS-1:0]  ex_rd;
    logic                 ex_mem_read;
    logic                 ex_write_en;
    logic                 ex_branch_taken;
    logic                 mem_req;
    logic                 mem_ready;

    // Pipeline register controls
    logic                 pc_en;
    logic                 pc_sel;
    logic                 if_id_en;
    logic                 if_id_flush;
    logic                 id_ex_en;
    logic                 id_ex_flush;
    logic                 ex_mem_en;

    // Status / performance
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic                 mem_error;

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_mem_read, ex_write_en, ex_branch_taken,
        output mem_req, mem_ready,
        input  pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
        input  stall_cnt, flush_cnt, mem_error
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_mem_read, ex_write_en, ex_branch_taken,
        input  mem_req, mem_ready,
        output pc_en, pc_sel, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en,
        output stall_cnt, flush_cnt, mem_error
    );

endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Purely combinational load-use detector. Flags when the
//                instruction in ID reads a register that a load in EX is
//                about to write (never for the zero register).
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  wire logic [REG_BITS-1:0] id_rs1,
    input  wire logic [REG_BITS-1:0] id_rs2,
    input  wire logic                id_uses_rs1,
    input  wire logic                id_uses_rs2,
    input  wire logic [REG_BITS-1:0] ex_rd,
    input  wire logic                ex_mem_read,
    input  wire logic                ex_write_en,
    output logic                     load_use
);

    logic w_ex_load_dst;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // Compare both ID sources against the destination of a producing load in EX
    always_comb begin
        w_ex_load_dst = ex_mem_read & ex_write_en & (ex_rd != REG_BITS'(REG_ZERO));
        w_rs1_hit     = id_uses_rs1 & (id_rs1 == ex_rd);
        w_rs2_hit     = id_uses_rs2 & (id_rs2 == ex_rd);
        load_use      = w_ex_load_dst & (w_rs1_hit | w_rs2_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Central hazard and sequencing controller for the 5-stage
//                pipeline. Generates PC / pipeline-register enables and
//                flushes for memory stalls, taken branches and load-use
//                hazards; keeps saturating stall/flush counters and a sticky
//                memory-timeout error.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_COUNT   = 32,
    parameter int REG_BITS    = $clog2(REG_COUNT),
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    pipeline_ctrl_if.slave  bus
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t          r_state;
    ctrl_state_t          w_next_state;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic                 r_mem_error;

    logic w_load_use;
    logic w_mem_busy;
    logic w_timeout;
    logic w_mem_stall;
    logic w_branch_act;
    logic w_pc_en;
    logic w_pc_sel;
    logic w_if_id_en;
    logic w_if_id_flush;
    logic w_id_ex_en;
    logic w_id_ex_flush;
    logic w_ex_mem_en;

    hazard_detect #(
        .REG_BITS    (REG_BITS)
    ) u_hazard_detect (
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .id_uses_rs1 (bus.id_uses_rs1),
        .id_uses_rs2 (bus.id_uses_rs2),
        .ex_rd       (bus.ex_rd),
        .ex_mem_read (bus.ex_mem_read),
        .ex_write_en (bus.ex_write_en),
        .load_use    (w_load_use)
    );

    // Next state and pipeline controls; memory stall outranks branch outranks load-use
    always_comb begin
        w_next_state  = r_state;
        w_pc_en       = 1'b1;
        w_pc_sel      = 1'b0;
        w_if_id_en    = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_en    = 1'b1;
        w_id_ex_flush = 1'b0;
        w_ex_mem_en   = 1'b1;
        w_branch_act  = 1'b0;

        w_mem_busy = mem_busy_f(bus.mem_req, bus.mem_ready);
        // The last permitted wait cycle abandons the access instead of stalling
        w_timeout  = (r_state == MEM_WAIT) & w_mem_busy & (r_wait_cnt == c_wait_last);
        // The completion cycle in MEM_WAIT is still stalled; the pipe moves next cycle
        w_mem_stall = (w_mem_busy | (r_state == MEM_WAIT)) & ~w_timeout;

        case (r_state)
            RUN: begin
                if (w_mem_busy) begin
                    w_next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (!w_mem_busy || w_timeout) begin
                    w_next_state = RUN;
                end
            end
            default: w_next_state = RUN;
        endcase

        if (w_mem_stall) begin
            // Freeze every stage; a pending branch stays in EX until release
            w_pc_en     = 1'b0;
            w_if_id_en  = 1'b0;
            w_id_ex_en  = 1'b0;
            w_ex_mem_en = 1'b0;
        end else if (bus.ex_branch_taken) begin
            // Redirect fetch and squash the two younger instructions
            w_pc_sel      = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_branch_act  = 1'b1;
        end else if (w_load_use) begin
            // Hold IF and ID for one cycle and inject a bubble into EX
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
        end
    end

    // State, wait counter, performance counters and sticky timeout error
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state <= w_next_state;

            if ((r_state == MEM_WAIT) && (w_next_state == MEM_WAIT)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end else begin
                r_wait_cnt <= '0;
            end

            if (!w_pc_en && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end

            if (w_branch_act && !(&r_flush_cnt)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_mem_error <= 1'b1;
            end
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.pc_sel      = w_pc_sel;
    assign bus.if_id_en    = w_if_id_en;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_en    = w_id_ex_en;
    assign bus.id_ex_flush = w_id_ex_flush;
    assign bus.ex_mem_en   = w_ex_mem_en;
    assign bus.stall_cnt   = r_stall_cnt;
    assign bus.flush_cnt   = r_flush_cnt;
    assign bus.mem_error   = r_mem_error;

endmodule
`default_nettype wire
